reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the number of stable synchronized button cycles required before a press or release is accepted (1 ms at 50 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, meaning the minimum number of cycles cpu_reset is held high.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning the width of the shared cycle counter.
REQ-004 clk  input  1  single system clock; all logic on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 pb_n  input  1  raw push button, active-low, asynchronous to clk.
REQ-007 cpu_led  input  8  CPU LED port, active-high.
REQ-008 cpu_reset  output  1  registered active-high CPU reset.
REQ-009 running  output  1  registered; 1 while the CPU is released from reset.
REQ-010 led_out  output  8  registered LED data, active-high; the top level inverts it for the board.

Function
REQ-011 SHALL synchronize pb_n through two flops, each resetting to 1, giving pb_sync.
REQ-012 SHALL implement FSM states HOLD, WAIT_RELEASE, RUN and WAIT_PRESS with one counter cnt.
REQ-013 HOLD: cnt increments each cycle; at cnt==HOLD_CYCLES-1 the FSM SHALL go to WAIT_RELEASE and clear cnt.
REQ-014 WAIT_RELEASE, pb_sync==1: cnt increments; at cnt==DEBOUNCE_CYCLES-1 the FSM SHALL go to RUN and clear cnt.
REQ-015 WAIT_RELEASE, pb_sync==0: cnt SHALL clear and the state SHALL be unchanged.
REQ-016 RUN, pb_sync==0: the FSM SHALL go to WAIT_PRESS with cnt=0.
REQ-017 WAIT_PRESS, pb_sync==0: cnt increments; at cnt==DEBOUNCE_CYCLES-1 the FSM SHALL go to HOLD with cnt=0.
REQ-018 WAIT_PRESS, pb_sync==1: the FSM SHALL return to RUN with cnt=0, so glitches shorter than DEBOUNCE_CYCLES are ignored.
REQ-019 cpu_reset SHALL be 1 in HOLD and WAIT_RELEASE and 0 in RUN and WAIT_PRESS, registered on the same edge as the state; running SHALL equal ~cpu_reset.
REQ-020 In RUN and WAIT_PRESS, led_out SHALL equal cpu_led delayed by one cycle; in HOLD and WAIT_RELEASE it SHALL be 8'h00 unless REQ-025 applies.
REQ-021 The counter SHALL be sized to CNT_WIDTH, and both parameters SHALL be >=1 and <2^CNT_WIDTH (elaboration check).

Reset
REQ-022 While reset_n==0: state=HOLD, cnt=0, cpu_reset=1, running=0, led_out=8'h00, synchronizer flops=1, event counter=0.
REQ-023 Assertion of reset_n at any time, including mid-WAIT_PRESS or mid-RUN, SHALL take effect immediately and asynchronously; the full HOLD -> WAIT_RELEASE sequence SHALL follow release.

Configuration
REQ-024 Macro RESET_SEQ_STATUS_LED_EN SHALL select the reset-state LED display.
REQ-025 When RESET_SEQ_STATUS_LED_EN is defined:
- a 4-bit event counter SHALL increment (mod 16) on each WAIT_PRESS->HOLD transition;
- in HOLD/WAIT_RELEASE, led_out SHALL be {1'b1, 3'b000, event_cnt}.
REQ-026 When RESET_SEQ_STATUS_LED_EN is undefined, the event counter SHALL be absent and REQ-020 SHALL apply unchanged.

Structure
REQ-027 Package reset_seq_pkg SHALL hold the state encoding localparams (2-bit: HOLD=0, WAIT_RELEASE=1, RUN=2, WAIT_PRESS=3) and the default DEBOUNCE/HOLD constants.
REQ-028 The two-flop synchronizer SHALL be sub-module sync_2ff with a reset-value parameter; all other logic SHALL be in reset_sequencer.

Verification (DEBOUNCE_CYCLES=8, HOLD_CYCLES=4)
REQ-029 Release reset_n with pb_n=1 -> cpu_reset falls after the 12th clk edge, running=1, and led_out tracks cpu_led with one-cycle lag.
REQ-030 In RUN, drive pb_n low for 5 cycles -> cpu_reset stays 0 and the FSM returns to RUN.
REQ-031 In RUN, drive pb_n low for 20 cycles then high -> cpu_reset rises after the 11th edge from the pb_n fall and falls 10 edges after the pb_n rise.
REQ-032 Hold pb_n low for 100 cycles with bounces (1-cycle highs every 5) -> cpu_reset stays high until 8 consecutive released synchronized cycles.
REQ-033 Assert reset_n mid-WAIT_PRESS -> cpu_reset=1 and led_out=8'h00 with no clock edge, and the sequence of REQ-029 repeats on release.
REQ-034 With RESET_SEQ_STATUS_LED_EN, perform two accepted button resets -> led_out=8'h82 during the second reset.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
//   Shared definitions for the reset sequencer: the 2-bit FSM state encoding,
//   the default timing constants, and a helper that tells which states keep
//   the CPU in reset.
package reset_seq_pkg;

  localparam logic [1:0] ST_HOLD         = 2'd0;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN          = 2'd2;
  localparam logic [1:0] ST_WAIT_PRESS   = 2'd3;

  typedef enum logic [1:0] {
    S_HOLD         = ST_HOLD,
    S_WAIT_RELEASE = ST_WAIT_RELEASE,
    S_RUN          = ST_RUN,
    S_WAIT_PRESS   = ST_WAIT_PRESS
  } state_t;

  // 1 ms of debounce at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int DEFAULT_HOLD_CYCLES     = 16;
  localparam int DEFAULT_CNT_WIDTH       = 16;

  // HOLD and WAIT_RELEASE keep the CPU in reset; RUN and WAIT_PRESS let it run
  function automatic logic in_reset_state(input state_t s);
    return (s == S_HOLD) || (s == S_WAIT_RELEASE);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
//   Board-side signal bundle of the reset sequencer.
//   pb_n      : raw active-low push button (asynchronous to clk)
//   cpu_led   : CPU LED port, active-high
//   cpu_reset : registered active-high CPU reset
//   running   : registered, 1 while the CPU is out of reset
//   led_out   : registered LED data, active-high
//   master = stimulus/board side, slave = reset_sequencer.
interface reset_sequencer_if;
  logic       pb_n;
  logic [7:0] cpu_led;
  logic       cpu_reset;
  logic       running;
  logic [7:0] led_out;

  modport master (
    output pb_n,
    output cpu_led,
    input  cpu_reset,
    input  running,
    input  led_out
  );

  modport slave (
    input  pb_n,
    input  cpu_led,
    output cpu_reset,
    output running,
    output led_out
  );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous input.
//   Ports: clk, reset_n (async active-low), i_d (async input), o_q (synced).
//   RESET_VAL is the value both flops take while reset is asserted.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Debounced push-button CPU reset generator. On power-up (and after every
//   accepted button press) the CPU is held in reset for at least HOLD_CYCLES,
//   then kept there until the button has been seen released for
//   DEBOUNCE_CYCLES consecutive synchronized cycles.
//   Ports: clk, reset_n (async active-low), bus (reset_sequencer_if.slave:
//   pb_n, cpu_led in; cpu_reset, running, led_out out).
//   Optional build macro RESET_SEQ_STATUS_LED_EN: counts accepted button
//   resets (mod 16) and shows {1'b1, 3'b000, count} on led_out while the CPU
//   is held in reset; without it led_out is 8'h00 during reset.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  reset_sequencer_if.slave  bus
);

  generate
    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_debounce
      $error("reset_sequencer: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
    end
    if (HOLD_CYCLES < 1 || longint'(HOLD_CYCLES) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_hold
      $error("reset_sequencer: HOLD_CYCLES out of range for CNT_WIDTH");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 w_pb_sync;
  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 r_cpu_reset;
  logic                 r_running;
  logic [7:0]           r_led_out;
  logic [7:0]           w_status_led;
  logic                 w_hold_next;

  sync_2ff #(.RESET_VAL(1'b1)) u_pb_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (bus.pb_n),
    .o_q     (w_pb_sync)
  );

  // One counter serves both the hold time and the debounce windows; it is
  // cleared on every state change so each window starts from zero.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CNT_WIDTH'(1);
    case (r_state)
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_next = S_WAIT_RELEASE;
          w_cnt_next   = '0;
        end
      end
      S_WAIT_RELEASE: begin
        if (!w_pb_sync) begin
          w_cnt_next = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
        end
      end
      S_RUN: begin
        w_cnt_next = '0;
        if (!w_pb_sync) begin
          w_state_next = S_WAIT_PRESS;
        end
      end
      S_WAIT_PRESS: begin
        if (w_pb_sync) begin
          // press too short: treat as a glitch
          w_state_next = S_RUN;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = S_HOLD;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = S_HOLD;
        w_cnt_next   = '0;
      end
    endcase
  end

`ifdef RESET_SEQ_STATUS_LED_EN
  logic [3:0] r_event_cnt;
  logic [3:0] w_event_next;

  assign w_event_next = (r_state == S_WAIT_PRESS && w_state_next == S_HOLD)
                        ? r_event_cnt + 4'd1 : r_event_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_event_cnt <= 4'd0;
    end else begin
      r_event_cnt <= w_event_next;
    end
  end

  // use the post-edge count so the display is current from the first HOLD cycle
  assign w_status_led = {1'b1, 3'b000, w_event_next};
`else
  assign w_status_led = 8'h00;
`endif

  // Outputs are derived from the next state so they change on the same edge
  // as the state register.
  assign w_hold_next = in_reset_state(w_state_next);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_HOLD;
      r_cnt       <= '0;
      r_cpu_reset <= 1'b1;
      r_running   <= 1'b0;
      r_led_out   <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_cpu_reset <= w_hold_next;
      r_running   <= ~w_hold_next;
      r_led_out   <= w_hold_next ? w_status_led : bus.cpu_led;
    end
  end

  assign bus.cpu_reset = r_cpu_reset;
  assign bus.running   = r_running;
  assign bus.led_out   = r_led_out;

endmodule
